csa_seq_adder_ctrl: RTL and testbench



---
 rtl/csa_seq_adder_ctrl_pkg.sv | 21 ++
 rtl/csa_seq_adder_ctrl_csa.sv | 90 +++++++++
 rtl/csa_seq_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_csa_seq_adder_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_seq_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csa_seq_adder_ctrl_pkg
// Shared definitions for the sequential carry-select adder controller:
// default chunk geometry and the controller FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package csa_seq_adder_ctrl_pkg;

  // Default geometry: a 12-bit add done as four 3-bit chunks.
  localparam int DEF_WIDTH  = 3;
  localparam int DEF_CHUNKS = 4;
  localparam int DEF_CNT_W  = 2;

  // Controller states; encodings are fixed so they can be probed by the lab top.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_seq_adder_ctrl_csa.sv
// ---------------------------------------------------------------------------
// FA / CSA
// FA  : single-bit full adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
// CSA : WIDTH-bit carry-select adder built from FA cells. The low half
//   ripples from ci; the high half is computed twice (carry-in 0 and 1) in
//   parallel and the real low-half carry picks one of the two results.
//   a, b     : WIDTH-bit operands
//   ci       : carry in
//   sum      : WIDTH-bit sum
//   co       : carry out
// ---------------------------------------------------------------------------
module FA (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module CSA #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  // Low half gets the extra bit for odd widths so it is never empty.
  localparam int LO_W = (WIDTH + 1) / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic [LO_W:0]   lo_c;
  logic [LO_W-1:0] lo_s;

  assign lo_c[0] = ci;

  for (genvar i = 0; i < LO_W; i++) begin : g_lo
    FA u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (lo_c[i]),
      .s  (lo_s[i]),
      .co (lo_c[i+1])
    );
  end

  if (HI_W > 0) begin : g_hi
    logic [HI_W:0]   c0;
    logic [HI_W:0]   c1;
    logic [HI_W-1:0] s0;
    logic [HI_W-1:0] s1;

    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;

    for (genvar j = 0; j < HI_W; j++) begin : g_bit
      FA u_fa0 (
        .a  (a[LO_W+j]),
        .b  (b[LO_W+j]),
        .ci (c0[j]),
        .s  (s0[j]),
        .co (c0[j+1])
      );
      FA u_fa1 (
        .a  (a[LO_W+j]),
        .b  (b[LO_W+j]),
        .ci (c1[j]),
        .s  (s1[j]),
        .co (c1[j+1])
      );
    end

    // The rippled low-half carry selects the precomputed high half.
    assign sum = {(lo_c[LO_W] ? s1 : s0), lo_s};
    assign co  = lo_c[LO_W] ? c1[HI_W] : c0[HI_W];
  end else begin : g_no_hi
    assign sum = lo_s;
    assign co  = lo_c[LO_W];
  end

endmodule

// File: rtl/csa_seq_adder_ctrl.sv
// ---------------------------------------------------------------------------
// csa_seq_adder_ctrl
// Adds two CHUNKS*WIDTH-bit operands by feeding one WIDTH-bit chunk per
// cycle (LS chunk first) through a single shared CSA, carrying each chunk's
// carry-out into the next chunk through a register.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   start  : request pulse, honoured only in IDLE or DONE
//   a, b   : operands, latched on the accepted start edge
//   ci     : carry into chunk 0, latched on the accepted start edge
//   busy   : high while chunks are being added
//   done   : one-cycle pulse when sum/co carry a fresh result
//   sum    : registered result, only updated on completion
//   co     : registered carry out of the MS chunk
// ---------------------------------------------------------------------------
module csa_seq_adder_ctrl
  import csa_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CHUNKS = DEF_CHUNKS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CHUNKS*WIDTH-1:0] a,
  input  logic [CHUNKS*WIDTH-1:0] b,
  input  logic                    ci,
  output logic                    busy,
  output logic                    done,
  output logic [CHUNKS*WIDTH-1:0] sum,
  output logic                    co
);

  localparam int TOTAL = CHUNKS * WIDTH;
  // Holds the chunks finished so far; the chunk being added this cycle
  // comes straight from the CSA, so one chunk less of storage is needed.
  localparam int RES_W = (CHUNKS > 1) ? (CHUNKS - 1) * WIDTH : 1;

  state_t state;
  state_t next_state;

  logic [TOTAL-1:0] a_reg;
  logic [TOTAL-1:0] b_reg;
  logic [RES_W-1:0] res_reg;
  logic [RES_W-1:0] res_next;
  logic [TOTAL-1:0] res_shift;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt;
  logic             last_chunk;
  logic             load;
  logic [WIDTH-1:0] csa_sum;
  logic             csa_co;

  CSA #(WIDTH) u_csa (
    .a   (a_reg[WIDTH-1:0]),
    .b   (b_reg[WIDTH-1:0]),
    .ci  (carry_reg),
    .sum (csa_sum),
    .co  (csa_co)
  );

  assign last_chunk = (cnt == CNT_W'(CHUNKS - 1));

  // New chunk sum enters at the top; after CHUNKS shifts chunk 0 sits at
  // the bottom, which is why res_shift is the full result on the last cycle.
  if (CHUNKS > 1) begin : g_multi
    assign res_shift = {csa_sum, res_reg};
    assign res_next  = res_shift[TOTAL-1:WIDTH];
  end else begin : g_single
    assign res_shift = csa_sum;
    assign res_next  = res_reg;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE and DONE both accept a start, which makes
  // back-to-back operation possible without an intervening IDLE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN:  if (last_chunk) next_state = DONE;
      DONE: next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / control decode from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: load = start;
      RUN:  busy = 1'b1;
      DONE: begin
        done = 1'b1;
        load = start;
      end
      default: ;
    endcase
  end

  // Datapath: operand shift registers, chunk carry, counter and the result
  // registers. sum/co only change on the last chunk so they never expose a
  // partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      co        <= 1'b0;
    end else if (load) begin
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= ci;
      cnt       <= '0;
    end else if (state == RUN) begin
      res_reg   <= res_next;
      carry_reg <= csa_co;
      a_reg     <= a_reg >> WIDTH;
      b_reg     <= b_reg >> WIDTH;
      cnt       <= cnt + 1'b1;
      if (last_chunk) begin
        sum <= res_shift;
        co  <= csa_co;
      end
    end
  end

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_seq_adder_ctrl
// Scoreboard bench: every accepted start pushes the expected {co,sum} (plain
// integer addition) and the start cycle; a monitor pops and compares on each
// done pulse, also checking latency. Directed scenarios cover reset, holding,
// ignored starts, mid-run reset and back-to-back, followed by random vectors.
// ---------------------------------------------------------------------------
module tb_csa_seq_adder_ctrl;

  localparam int WIDTH  = 3;
  localparam int CHUNKS = 4;
  localparam int CNT_W  = 2;
  localparam int TOTAL  = WIDTH * CHUNKS;

  logic             clk;
  logic             reset;
  logic             start;
  logic [TOTAL-1:0] a;
  logic [TOTAL-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [TOTAL-1:0] sum;
  logic             co;

  int tests_run   = 0;
  int tests_fail  = 0;
  int cycle_cnt   = 0;
  int done_pulses = 0;
  int rand_loops  = 0;

  logic [TOTAL:0] exp_q[$];
  int             start_q[$];

  csa_seq_adder_ctrl #(
    .WIDTH  (WIDTH),
    .CHUNKS (CHUNKS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  // Free-running clock and edge counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge: present a request for one edge, then scramble the
  // operand pins so any late sampling would corrupt the result.
  task automatic applyStimulus(input logic [TOTAL-1:0] av, input logic [TOTAL-1:0] bv,
                               input logic civ, input bit expect_it);
    a     = av;
    b     = bv;
    ci    = civ;
    start = 1'b1;
    if (expect_it) exp_q.push_back({1'b0, av} + {1'b0, bv} + {{TOTAL{1'b0}}, civ});
    @(posedge clk);
    #1;
    if (expect_it) start_q.push_back(cycle_cnt);
    start = 1'b0;
    a     = TOTAL'($urandom);
    b     = TOTAL'($urandom);
    ci    = 1'($urandom);
  endtask

  // Bounded wait for done, counting busy cycles seen beforehand.
  task automatic waitDone(output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: pop the scoreboard on every done pulse.
  always @(negedge clk) begin
    logic [TOTAL:0] e;
    int             s;
    if (!reset && done) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = start_q.pop_front();
        checkOutput("result", 32'({co, sum}), 32'(e));
        checkOutput("latency", 32'(cycle_cnt - s), 32'(CHUNKS));
      end
    end
  end

  initial begin
    int bc;
    int pulses_before;
    bit saw_done;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_co", 32'(co), 32'd0);

    // Full carry propagation across all chunks.
    @(negedge clk);
    applyStimulus(12'hFFF, 12'h001, 1'b0, 1'b1);
    waitDone(bc);
    checkOutput("busy_cycles", 32'(bc), 32'(CHUNKS));

    // Mixed operands with carry-in, then results must hold while idle.
    @(negedge clk);
    applyStimulus(12'h5A3, 12'h2C4, 1'b1, 1'b1);
    waitDone(bc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_sum", 32'(sum), 32'h868);
      checkOutput("hold_co", 32'(co), 32'd0);
    end

    // Operand changes and a second start during RUN must be ignored.
    pulses_before = done_pulses;
    applyStimulus(12'h123, 12'h456, 1'b0, 1'b1);
    @(negedge clk);
    a     = 12'hFFF;
    b     = 12'hFFF;
    ci    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(bc);
    repeat (8) @(negedge clk);
    checkOutput("single_done", 32'(done_pulses - pulses_before), 32'd1);

    // Reset in the second RUN cycle aborts without a done pulse.
    applyStimulus(12'h777, 12'h111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_co", 32'(co), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'd0);
    applyStimulus(12'hABC, 12'h135, 1'b1, 1'b1);
    waitDone(bc);

    // Back-to-back: new start issued in the DONE cycle itself.
    @(negedge clk);
    applyStimulus(12'h3C5, 12'h0F0, 1'b0, 1'b1);
    waitDone(bc);
    applyStimulus(12'h800, 12'h800, 1'b0, 1'b1);
    checkOutput("no_idle_gap", 32'(busy), 32'd1);
    waitDone(bc);

    // Random vectors, mostly back-to-back to keep the pipe busy.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) @(negedge clk);
      applyStimulus(TOTAL'($urandom), TOTAL'($urandom), 1'($urandom), 1'b1);
      waitDone(bc);
      rand_loops++;
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    if (tests_fail == 0 && rand_loops > 0) $display("Test Passed - %m");
    else $display("Test Failed - %m");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
